// File: rtl/vga_text_pkg.sv
// vga_text_pkg: text-mode geometry, pixel type and the built-in font contents.
// The font function stands in for the font file and is the ROM's only source of truth.
package vga_text_pkg;
    localparam int TEXT_COLS = 80;
    localparam int TEXT_ROWS = 30;
    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;
    localparam int BUF_DEPTH = 2400;
    localparam int BUF_AW = 12;
    localparam int FONT_AW = 11;
    localparam int LATENCY = 3;

    typedef logic [7:0] rgb332_t;

    localparam logic [7:0] GLYPH_A [16] = '{
        8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
        8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00
    };

    // Codes without a drawn glyph show their code bits plus a bottom bar.
    function automatic logic [7:0] font_glyph(input logic [FONT_AW-1:0] a);
        logic [6:0] c;
        logic [3:0] r;
        c = a[10:4];
        r = a[3:0];
        return (c == 7'h41) ? GLYPH_A[r] :
               (c == 7'h7F) ? 8'hFF :
               (c == 7'h20) ? 8'h00 :
               (r == 4'(CHAR_H - 1)) ? 8'hFF : {1'b0, c};
    endfunction
endpackage

// File: rtl/vga_text_gen_if.sv
// vga_text_gen_if: timing inputs, character-buffer write port and VGA outputs.
// Cursor position signals exist only with VGA_TEXT_CURSOR_EN.
interface vga_text_gen_if;
    import vga_text_pkg::*;
    logic pix_en;
    logic [9:0] pixel_x;
    logic [8:0] pixel_y;
    logic video_on;
    logic hsync_in;
    logic vsync_in;
    logic wr_en;
    logic [BUF_AW-1:0] wr_addr;
    logic [7:0] wr_data;
    rgb332_t rgb;
    logic hsync;
    logic vsync;
`ifdef VGA_TEXT_CURSOR_EN
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;
    modport master (output pix_en, pixel_x, pixel_y, video_on, hsync_in, vsync_in,
                    wr_en, wr_addr, wr_data, cursor_col, cursor_row,
                    input rgb, hsync, vsync);
    modport slave (input pix_en, pixel_x, pixel_y, video_on, hsync_in, vsync_in,
                   wr_en, wr_addr, wr_data, cursor_col, cursor_row,
                   output rgb, hsync, vsync);
`else
    modport master (output pix_en, pixel_x, pixel_y, video_on, hsync_in, vsync_in,
                    wr_en, wr_addr, wr_data,
                    input rgb, hsync, vsync);
    modport slave (input pix_en, pixel_x, pixel_y, video_on, hsync_in, vsync_in,
                   wr_en, wr_addr, wr_data,
                   output rgb, hsync, vsync);
`endif
endinterface

// File: rtl/vga_font_rom.sv
// vga_font_rom: 2048x8 glyph ROM (char x 16 rows) with registered read on pixel ticks.
module vga_font_rom
    import vga_text_pkg::*;
(
    input  logic               clk,
    input  logic               en,
    input  logic [FONT_AW-1:0] addr,
    output logic [7:0]         data
);
    always_ff @(posedge clk)
        if (en) data <= font_glyph(addr);
endmodule

// File: rtl/vga_text_gen.sv
// vga_text_gen: 80x30 text pixel stage, three pixel-tick pipeline with aligned syncs.
// Define VGA_TEXT_CURSOR_EN for a blinking underline cursor.
module vga_text_gen
    import vga_text_pkg::*;
#(
    parameter rgb332_t FG_COLOR = 8'hFF,
    parameter rgb332_t BG_COLOR = 8'h00
) (
    input logic clk,
    input logic reset,
    vga_text_gen_if.slave bus
);
    logic [7:0] buffer [BUF_DEPTH];
    logic [BUF_AW-1:0] char_addr;
    logic in_grid;
    logic [7:0] char_q;
    logic [2:0] col1, col2;
    logic [3:0] row1;
    logic von1, von2, inv2;
    logic [LATENCY-1:0] hs_d, vs_d;
    logic [7:0] font_q, glyph;
    logic pix;

    assign in_grid = (bus.pixel_y[8:4] < 5'(TEXT_ROWS)) && (bus.pixel_x[9:3] < 7'(TEXT_COLS));
    assign char_addr = BUF_AW'(bus.pixel_y[8:4]) * BUF_AW'(TEXT_COLS) + BUF_AW'(bus.pixel_x[9:3]);

    // Write and read share the edge, so a same-address read sees the old byte.
    always_ff @(posedge clk) begin
        if (bus.wr_en && bus.wr_addr < BUF_AW'(BUF_DEPTH)) buffer[bus.wr_addr] <= bus.wr_data;
        if (bus.pix_en) char_q <= in_grid ? buffer[char_addr] : 8'h00;
    end

    vga_font_rom u_font (
        .clk  (clk),
        .en   (bus.pix_en),
        .addr ({char_q[6:0], row1}),
        .data (font_q)
    );

`ifdef VGA_TEXT_CURSOR_EN
    logic vs_prev, cur1, cur2;
    logic [4:0] frame_cnt;
    logic [3:0] row2;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_prev <= 1'b1;
            frame_cnt <= '0;
            cur1 <= 1'b0;
            cur2 <= 1'b0;
            row2 <= '0;
        end else begin
            vs_prev <= bus.vsync_in;
            if (vs_prev && !bus.vsync_in) frame_cnt <= frame_cnt + 5'd1;
            if (bus.pix_en) begin
                cur1 <= frame_cnt[4] && in_grid && bus.pixel_y[8:4] == bus.cursor_row
                        && bus.pixel_x[9:3] == bus.cursor_col;
                cur2 <= cur1;
                row2 <= row1;
            end
        end
    end
    assign glyph = (cur2 && row2 >= 4'(CHAR_H - 2)) ? 8'hFF : font_q;
`else
    assign glyph = font_q;
`endif

    assign pix = glyph[3'(CHAR_W - 1) - col2] ^ inv2;
    assign bus.hsync = hs_d[LATENCY-1];
    assign bus.vsync = vs_d[LATENCY-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col1 <= '0;
            row1 <= '0;
            von1 <= 1'b0;
            col2 <= '0;
            von2 <= 1'b0;
            inv2 <= 1'b0;
            hs_d <= '1;
            vs_d <= '1;
            bus.rgb <= 8'h00;
        end else if (bus.pix_en) begin
            col1 <= bus.pixel_x[2:0];
            row1 <= bus.pixel_y[3:0];
            von1 <= bus.video_on;
            col2 <= col1;
            von2 <= von1;
            inv2 <= char_q[7];
            hs_d <= {hs_d[LATENCY-2:0], bus.hsync_in};
            vs_d <= {vs_d[LATENCY-2:0], bus.vsync_in};
            bus.rgb <= von2 ? (pix ? FG_COLOR : BG_COLOR) : 8'h00;
        end
    end
endmodule

// File: tb/tb_vga_text_gen.sv
// tb_vga_text_gen: scoreboard bench; expected pixels come from a shadow buffer and glyph table.
module tb_vga_text_gen;
    import vga_text_pkg::*;

    typedef struct packed {
        logic [7:0] rgb;
        logic hs;
        logic vs;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vga_text_gen_if bus();
    vga_text_gen dut (.clk(clk), .reset(reset), .bus(bus));

    logic [7:0] mem [BUF_DEPTH];
    logic [7:0] a_rows [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                                8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_t q[$];
    exp_t last, mon_e;
    logic en_s, rst_s;
    int vectors = 0;
    int miscompares = 0;
    int frames = 0;
    logic prev_vs = 1'b1;
    int cur_col = 127;
    int cur_row = 31;

    function automatic logic [7:0] glyph_row(input logic [6:0] c, input int r);
        if (c == 7'h41) return a_rows[r];
        if (c == 7'h7F) return 8'hFF;
        return 8'h00;
    endfunction

    function automatic logic [7:0] exp_rgb(input int x, input int y, input logic von);
        int col, row;
        logic [7:0] ch, g;
        if (!von) return 8'h00;
        col = x / 8;
        row = y / 16;
        ch = mem[row * 80 + col];
        g = glyph_row(ch[6:0], y % 16);
        if (frames % 32 >= 16 && col == cur_col && row == cur_row && y % 16 >= 14) g = 8'hFF;
        return (g[7 - x % 8] ^ ch[7]) ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [7:0] rand_char();
        logic [7:0] c;
        case ($urandom % 3)
            0: c = 8'h20;
            1: c = 8'h41;
            default: c = 8'h7F;
        endcase
        return c | (($urandom % 2) == 1 ? 8'h80 : 8'h00);
    endfunction

    task automatic check(input string name, input exp_t want);
        exp_t got;
        got = {bus.rgb, bus.hsync, bus.vsync};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: rgb=%h hsync=%b vsync=%b, expected rgb=%h hsync=%b vsync=%b",
                     name, got.rgb, got.hs, got.vs, want.rgb, want.hs, want.vs);
        end
    endtask

    task automatic tick(input int x, input int y, input logic von, input logic hs,
                        input logic vs, input int gap, input int wa, input logic [7:0] wd);
        exp_t e;
        bus.pixel_x = 10'(x);
        bus.pixel_y = 9'(y);
        bus.video_on = von;
        bus.hsync_in = hs;
        bus.vsync_in = vs;
        bus.pix_en = 1'b1;
        e.rgb = exp_rgb(x, y, von);
        e.hs = hs;
        e.vs = vs;
        q.push_back(e);
        if (wa >= 0) begin
            bus.wr_en = 1'b1;
            bus.wr_addr = 12'(wa);
            bus.wr_data = wd;
        end
        if (prev_vs && !vs) frames++;
        prev_vs = vs;
        @(posedge clk); #1;
        bus.pix_en = 1'b0;
        bus.wr_en = 1'b0;
        if (wa >= 0 && wa < BUF_DEPTH) mem[wa] = wd;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        bus.wr_en = 1'b1;
        bus.wr_addr = 12'(a);
        bus.wr_data = d;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        if (a < BUF_DEPTH) mem[a] = d;
    endtask

    task automatic release_reset();
        exp_t r;
        r = '{rgb: 8'h00, hs: 1'b1, vs: 1'b1};
        reset = 1'b1;
        frames = 0;
        prev_vs = 1'b1;
        q.push_back(r);
        q.push_back(r);
    endtask

    // Outputs are checked on every edge: popped on pixel ticks, held otherwise.
    always begin
        @(posedge clk);
        en_s = bus.pix_en;
        rst_s = reset;
        #2;
        if (!rst_s) last = '{rgb: 8'h00, hs: 1'b1, vs: 1'b1};
        else if (en_s) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL scoreboard_empty: output seen with no expected entry");
            end else begin
                mon_e = q.pop_front();
                check("pipeline", mon_e);
            end
            last = {bus.rgb, bus.hsync, bus.vsync};
        end else check("hold", last);
    end

    initial begin
        bus.pix_en = 1'b0;
        bus.pixel_x = '0;
        bus.pixel_y = '0;
        bus.video_on = 1'b0;
        bus.hsync_in = 1'b1;
        bus.vsync_in = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
`ifdef VGA_TEXT_CURSOR_EN
        bus.cursor_col = 7'd127;
        bus.cursor_row = 5'd31;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", '{rgb: 8'h00, hs: 1'b1, vs: 1'b1});
        release_reset();
        for (int i = 0; i < BUF_DEPTH; i++) wr(i, rand_char());

        wr(0, 8'h41);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 8; x++) tick(x, y, 1'b1, 1'b1, 1'b1, 3, -1, 8'h00);

        wr(2399, 8'hC1);
        for (int y = 464; y < 480; y++)
            for (int x = 632; x < 640; x++) tick(x, y, 1'b1, 1'b1, 1'b1, 0, -1, 8'h00);

        wr(2400, 8'h7F);
        wr(4095, 8'hC1);
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                tick(c * 8 + int'($urandom % 8), r * 16 + int'($urandom % 16), 1'b1, 1'b1, 1'b1, 0, -1, 8'h00);

        for (int i = 0; i < 110; i++) tick(640 + i, 490, 1'b0, (i >= 4 && i < 100) ? 1'b0 : 1'b1, 1'b1, 0, -1, 8'h00);
        for (int i = 0; i < 6; i++) tick(700, 490 + i, 1'b0, 1'b1, (i == 2 || i == 3) ? 1'b0 : 1'b1, 0, -1, 8'h00);

        for (int x = 100; x < 108; x++) tick(x, 37, 1'b1, 1'b1, 1'b1, (x == 103) ? 10 : 0, -1, 8'h00);

        wr(2 * 80 + 5, 8'h41);
        tick(40, 34, 1'b1, 1'b1, 1'b1, 0, 2 * 80 + 5, 8'hFF);
        tick(40, 34, 1'b1, 1'b1, 1'b1, 0, -1, 8'h00);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom % 4 == 0) wr(int'($urandom % 4096), rand_char());
            tick(int'($urandom % 640), int'($urandom % 480), ($urandom % 8) != 0, ($urandom % 2) == 1,
                 1'b1, int'($urandom % 4), ($urandom % 8 == 0) ? int'($urandom % 2400) : -1, rand_char());
        end

        for (int x = 200; x < 206; x++) tick(x, 100, 1'b1, 1'b0, 1'b1, 0, -1, 8'h00);
        #2 reset = 1'b0;
        #1;
        check("reset_midline", '{rgb: 8'h00, hs: 1'b1, vs: 1'b1});
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        release_reset();
        for (int x = 0; x < 16; x++) tick(x, 5, 1'b1, 1'b1, 1'b1, 1, -1, 8'h00);

`ifdef VGA_TEXT_CURSOR_EN
        bus.cursor_col = 7'd0;
        bus.cursor_row = 5'd0;
        cur_col = 0;
        cur_row = 0;
        wr(0, 8'h20);
        for (int f = 0; f < 33; f++) begin
            tick(700, 490, 1'b0, 1'b1, 1'b0, 0, -1, 8'h00);
            tick(700, 491, 1'b0, 1'b1, 1'b1, 0, -1, 8'h00);
            for (int y = 13; y < 16; y++)
                for (int x = 0; x < 8; x += 3) tick(x, y, 1'b1, 1'b1, 1'b1, 0, -1, 8'h00);
        end
        bus.cursor_col = 7'd80;
        for (int x = 0; x < 8; x++) tick(632 + x, 14, 1'b1, 1'b1, 1'b1, 0, -1, 8'h00);
`endif

        for (int i = 0; i < 4; i++) tick(650, 490, 1'b0, 1'b1, 1'b1, 0, -1, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vga_text_gen.md
Name: vga_text_gen

Overview:
Pixel-generation stage directly downstream of the 640x480 sync generator. Consumes pixel_x/pixel_y/video_on/hsync/vsync and produces 8-bit RGB from an 80x30 character buffer and an 8x16 font ROM. The character buffer is written by the system side. All sync/blank signals are delayed through the same pipeline so they stay aligned with RGB at the VGA connector.

Parameters:
FG_COLOR, 8'hFF, foreground RGB332 colour for set font bits
BG_COLOR, 8'h00, background RGB332 colour inside the display area
LATENCY, 3, pipeline depth in pixel ticks; fixed, not user-tunable, exported for benches

Ports:
clk  in  1  single system clock (100 MHz)
reset  in  1  asynchronous, active-low reset
pix_en  in  1  pixel tick (25 MHz enable); pipeline advances only when high
pixel_x  in  10  current column from sync generator
pixel_y  in  9  current row from sync generator
video_on  in  1  display-area flag from sync generator
hsync_in  in  1  active-low hsync from sync generator
vsync_in  in  1  active-low vsync from sync generator
wr_en  in  1  character buffer write strobe
wr_addr  in  12  buffer address = row*80+col
wr_data  in  8  bit7 = inverse video, bits6:0 = ASCII code
rgb  out  8  RGB332 pixel
hsync  out  1  delayed hsync, active-low
vsync  out  1  delayed vsync, active-low

Behaviour:
- Reset (reset=0, async): rgb=0, hsync=1, vsync=1, all pipeline valid/blank bits cleared (blank). Character RAM contents are not reset.
- Write port: independent of pix_en. On any clk with wr_en=1 and wr_addr<2400, buffer[wr_addr]<=wr_data. wr_addr>=2400 is ignored with no side effect.
- Read/write collision on the same address in the same cycle: read returns the old data. The write is visible on the next read.
- Pipeline: each stage register loads only on clk edges with pix_en=1. Otherwise it holds.
  - S1: char_addr = pixel_y[8:4]*80 + pixel_x[9:3], computed in 12-bit unsigned. Synchronous RAM read. Delay pixel_x[2:0], pixel_y[3:0], video_on, hsync_in, vsync_in.
  - S2: font ROM address = {char[6:0], row[3:0]} (11 bits). Registered read gives an 8-bit row. Delay inverse bit, column, video_on, hsync_in, vsync_in.
  - S3: bit = font_row[7 - col]; pix = bit XOR inverse. rgb <= video_on_d ? (pix ? FG_COLOR : BG_COLOR) : 8'h00. hsync/vsync <= delayed inputs.
- Latency: exactly 3 pix_en ticks from input to rgb/hsync/vsync, identical for all three outputs.
- Outside the display area (video_on=0), rgb is forced to 0 regardless of buffer contents.
- Reset asserted mid-frame: outputs go to reset values immediately. After release, the first valid rgb appears 3 pix_en ticks after the first sampled input.

Optional Feature:
Macro VGA_TEXT_CURSOR_EN.
- When defined:
  - Adds ports cursor_col in 7 and cursor_row in 5.
  - A 5-bit frame counter increments on each vsync_in falling edge, detected in the clk domain via a registered previous value. The counter resets to 0 and wraps at 31.
  - When frame_cnt[4]=1 and the current cell equals (cursor_row, cursor_col), rows 14-15 of the glyph are forced to 8'hFF before the S3 inverse is applied. The cursor is therefore visible for 16 frames and hidden for 16 frames.
  - cursor_col>=80 or cursor_row>=30 means no cursor is drawn.
- When undefined: no cursor ports, no frame counter, output is identical to the base behaviour.

Decomposition:
- Package vga_text_pkg holds:
  - TEXT_COLS=80, TEXT_ROWS=30, CHAR_W=8, CHAR_H=16
  - BUF_DEPTH=2400, BUF_AW=12, FONT_AW=11
  - the rgb332_t typedef
- One sub-module, vga_font_rom: 2048x8 ROM, synchronous registered read, initialised from a font file. It is the S2 stage storage.
- The character RAM is inferred inline in vga_text_gen.

Test Plan:
- Write 0x41 to addr 0. Sweep pixel_x 0..7, pixel_y 0..15 with pix_en every 4th clk → rgb equals FG/BG per the 'A' font rows, each pixel 3 pix_en later.
- Write 0xC1 (inverse 'A') to addr 2399 → the cell at x=632..639, y=464..479 shows the bitwise complement of the 'A' pattern.
- Write to wr_addr=2400 and 4095 → no buffer location changes (full readback sweep matches the prior image).
- Toggle hsync_in/vsync_in low for 96/2 ticks with video_on=0 → hsync/vsync follow exactly 3 pix_en later, and rgb=0 throughout.
- Hold pix_en=0 for 10 clks mid-line → rgb, hsync and vsync are frozen; resume → sequence continues without a gap or duplicate.
- Assert reset mid-line → rgb=0, hsync=vsync=1 immediately. With VGA_TEXT_CURSOR_EN, cursor=(0,0) and 32 vsync pulses → underline present in frames 16-31 only.
